queue_module: RTL and testbench
===============================

Name: queue_module

Overview:
- Synchronous single-clock FIFO channel for the KPN process network. It carries 16-bit tokens between a producer and a consumer process.
- Reset preloads the queue with a configurable number of initial tokens, so a consumer can issue reads before any producer write.
- Read data is registered on output_1; write side, status flags and occupancy count are exposed for the surrounding network.

Parameters:
- DATA_W, 16, token width in bits (output_1/input_1 width).
- DEPTH, 8, number of storage entries; power of two, >= 2.
- INIT_COUNT, 4, tokens present after reset; 0..DEPTH.
- INIT_BASE, 16'd1, value of first preloaded token; entry i holds INIT_BASE+i (mod 2^DATA_W).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd  input  1  read request, sampled on rising edge of clk.
- output_1  output  DATA_W  registered head token from the last accepted read.
- wr  input  1  write request.
- input_1  input  DATA_W  token to enqueue when wr accepted.
- full  output  1  count==DEPTH (combinational from count).
- empty  output  1  count==0.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  one-cycle pulse: wr rejected because full.
- underflow  output  1  one-cycle pulse: rd rejected because empty.

Behaviour:
- Reset (rst_n=0, asynchronous): output_1=0, overflow=0, underflow=0, rd_ptr=0, wr_ptr=INIT_COUNT mod DEPTH, count=INIT_COUNT, mem[i]=INIT_BASE+i for i<INIT_COUNT, remaining entries=0.
- Reset while reads/writes are in flight: all state is reloaded immediately. Nothing in flight survives.
- Accepted read (rd=1 and count>0 at the edge): output_1 <= mem[rd_ptr], rd_ptr advances, count decrements. Latency is one cycle, so output_1 is valid after the edge that accepts rd.
- output_1 holds its last value when no read is accepted. This applies with rd=0 and also on a rejected read.
- Rejected read (rd=1, count==0): underflow=1 for one cycle; pointers, count and output_1 unchanged.
- Accepted write (wr=1, count<DEPTH, or count==DEPTH with a simultaneous accepted read): mem[wr_ptr] <= input_1, wr_ptr advances, count increments.
- Rejected write (wr=1, full and no accepted read): overflow=1 for one cycle; no state change.
- Simultaneous rd and wr:
  - Non-empty, non-full: both proceed, count unchanged.
  - Full: both proceed, count stays DEPTH.
  - Empty: write proceeds, read is rejected with an underflow pulse, count becomes 1. There is no write-to-read bypass.
- Pointers wrap from DEPTH-1 to 0.
- count never exceeds DEPTH and never goes below 0.
- Tokens leave in strict FIFO order.

Decomposition:
- Shared package kpn_pkg: DATA_W default constant, token typedef (logic [DATA_W-1:0]), and a clog2 helper if the toolflow needs it.
- One sub-module, queue_mem: dual-port register array with one write port and one read port. It is also responsible for the reset preload.
- queue_module holds the pointers, count, flags and output register.

Test Plan:
- Reset preload: hold rst_n=0, release, pulse rd for one cycle -> output_1=1 after that edge, count 4->3, empty=0.
- Drain: with defaults, assert rd for 5 consecutive cycles -> output_1 sequence 1,2,3,4, then held at 4. underflow=1 on the 5th cycle, count=0, empty=1.
- Fill and overflow: from empty, write 16'hA000..16'hA007 (8 writes) -> full=1, count=8. A 9th write (16'hBEEF) gives overflow=1, and subsequent reads return A000..A007 in order.
- Simultaneous full: full queue, rd=1, wr=1 with 16'h1234 -> count stays 8, output_1=head value, 16'h1234 is read back last.
- Simultaneous empty: empty queue, rd=1, wr=1 with 16'h00FF -> underflow=1, count=1, output_1 unchanged. The next rd gives output_1=16'h00FF.
- Async reset mid-stream: after 2 reads and 3 writes, drop rst_n between clock edges -> output_1=0, count=4 and empty=0 immediately without a clock edge; a subsequent read returns 1.

Source files
------------

// File: rtl/kpn_pkg.sv
// Shared types and constants for KPN channel blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kpn_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] token_t;

  // Ceiling log2 for sizing pointer and occupancy fields; returns 1 for v<=2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/queue_mem.sv
// Register-array storage for a KPN channel: one write port, one async read port, reset preload.
// Latency: write lands on the next rising edge; read data is combinational from the address.
// Backpressure: none; the controller decides when the write enable is safe.
module queue_mem
  import kpn_pkg::*;
#(
  parameter int                   DATA_W     = kpn_pkg::DATA_W,
  parameter int                   DEPTH      = 8,
  parameter int                   INIT_COUNT = 4,
  parameter logic [DATA_W-1:0]    INIT_BASE  = 1,
  parameter int                   AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Preload the first INIT_COUNT entries with an incrementing token sequence; write port otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < INIT_COUNT) ? DATA_W'(INIT_BASE + DATA_W'(i)) : '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/queue_module.sv
// KPN FIFO channel with reset-preloaded tokens, registered read data and status flags.
// Latency: output_1 updates on the edge that accepts rd; writes visible to reads one edge later.
// Backpressure: rejected writes pulse overflow, rejected reads pulse underflow; a full queue accepts a write alongside a read.
module queue_module
  import kpn_pkg::*;
#(
  parameter int                DATA_W     = kpn_pkg::DATA_W,
  parameter int                DEPTH      = 8,
  parameter int                INIT_COUNT = 4,
  parameter logic [DATA_W-1:0] INIT_BASE  = 16'd1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd,
  output logic [DATA_W-1:0]          output_1,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          input_1,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] head;
  logic              rd_ok;
  logic              wr_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full queue can still take a write when the same edge frees a slot; empty never bypasses.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);

  queue_mem #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .INIT_COUNT (INIT_COUNT),
    .INIT_BASE  (INIT_BASE),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (input_1),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer, occupancy, output register and one-cycle reject pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= AW'(INIT_COUNT % DEPTH);
      count     <= CW'(INIT_COUNT);
      output_1  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr && !wr_ok;
      underflow <= rd && !rd_ok;
      if (rd_ok) begin
        output_1 <= head;
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({rd_ok, wr_ok})
        2'b10:   count <= count - 1'b1;
        2'b01:   count <= count + 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_module.sv
// Directed bench for queue_module: vector table from reset plus a mid-stream async reset sequence.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: overflow/underflow pulses checked against hand-computed expectations.
module tb_queue_module;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [15:0] input_1;
  logic [15:0] output_1;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] din;
    logic [15:0] exp_out;
    logic [3:0]  exp_cnt;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vq[$];

  queue_module dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd        (rd),
    .output_1  (output_1),
    .wr        (wr),
    .input_1   (input_1),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [15:0] d, input logic [15:0] o,
                     input logic [3:0] c, input logic f, input logic e, input logic ov, input logic un);
    vec_t v;
    v.rd = r; v.wr = w; v.din = d; v.exp_out = o; v.exp_cnt = c;
    v.exp_full = f; v.exp_empty = e; v.exp_ovf = ov; v.exp_unf = un;
    vq.push_back(v);
  endtask

  task automatic check_all(input int idx, input logic [15:0] o, input logic [3:0] c,
                           input logic f, input logic e, input logic ov, input logic un);
    chk("output_1", idx, 32'(output_1), 32'(o));
    chk("count", idx, 32'(count), 32'(c));
    chk("full", idx, 32'(full), 32'(f));
    chk("empty", idx, 32'(empty), 32'(e));
    chk("overflow", idx, 32'(overflow), 32'(ov));
    chk("underflow", idx, 32'(underflow), 32'(un));
  endtask

  task automatic cycle(input logic r, input logic w, input logic [15:0] d);
    rd = r; wr = w; input_1 = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_reset();
    rd = 1'b0; wr = 1'b0; input_1 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // rd wr din        out       cnt full empty ovf unf
    add(1, 0, 16'h0000, 16'h0001, 3, 0, 0, 0, 0);   // preload head
    add(1, 0, 16'h0000, 16'h0002, 2, 0, 0, 0, 0);
    add(1, 0, 16'h0000, 16'h0003, 1, 0, 0, 0, 0);
    add(1, 0, 16'h0000, 16'h0004, 0, 0, 1, 0, 0);
    add(1, 0, 16'h0000, 16'h0004, 0, 0, 1, 0, 1);   // underflow, output held
    for (int k = 0; k < 8; k++)                      // fill, wr_ptr wraps from 7 to 0
      add(0, 1, 16'hA000 + 16'(k), 16'h0004, 4'(k + 1), (k == 7), 0, 0, 0);
    add(0, 1, 16'hBEEF, 16'h0004, 8, 1, 0, 1, 0);   // overflow
    add(1, 1, 16'h1234, 16'hA000, 8, 1, 0, 0, 0);   // simultaneous on full
    for (int k = 1; k < 8; k++)
      add(1, 0, 16'h0000, 16'hA000 + 16'(k), 4'(8 - k), 0, 0, 0, 0);
    add(1, 0, 16'h0000, 16'h1234, 0, 0, 1, 0, 0);   // 1234 read back last
    add(1, 1, 16'h00FF, 16'h1234, 1, 0, 0, 0, 1);   // simultaneous on empty: no bypass
    add(1, 0, 16'h0000, 16'h00FF, 0, 0, 1, 0, 0);
    add(0, 0, 16'h0000, 16'h00FF, 0, 0, 1, 0, 0);   // idle hold, pulses cleared

    do_reset();
    check_all(-1, 16'h0000, 4, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].rd, vq[i].wr, vq[i].din);
      check_all(i, vq[i].exp_out, vq[i].exp_cnt, vq[i].exp_full,
                vq[i].exp_empty, vq[i].exp_ovf, vq[i].exp_unf);
    end

    // Async reset mid-stream: 2 reads, 3 writes, then reset between edges.
    do_reset();
    cycle(1, 0, 16'h0000);
    cycle(1, 0, 16'h0000);
    chk("ar_out_pre", 0, 32'(output_1), 32'h0002);
    cycle(0, 1, 16'hC001);
    cycle(0, 1, 16'hC002);
    cycle(0, 1, 16'hC003);
    chk("ar_cnt_pre", 0, 32'(count), 32'd5);
    #1;
    rst_n = 1'b0;
    #2;
    chk("ar_out", 0, 32'(output_1), 32'h0000);
    chk("ar_cnt", 0, 32'(count), 32'd4);
    chk("ar_empty", 0, 32'(empty), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 0, 16'h0000);
    chk("ar_out_post", 0, 32'(output_1), 32'h0001);
    chk("ar_cnt_post", 0, 32'(count), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
